wb_delay_buf: RTL and testbench
===============================

Name: wb_delay_buf

Overview:
Parametrised writeback delay buffer for the Skylark-V load path. It replaces the fixed one-cycle W→W2 register stage with a DEPTH-entry shift pipeline that carries {we, rd, data} from writeback toward the register file. Each stage exposes a forwarding lookup so the hazard unit can source operands still in flight. Stall and flush controls let the pipeline freeze or squash pending writes.

Parameters:
DEPTH, 2, number of delay stages (≥1); DEPTH=1 gives the legacy one-cycle delay.
XLEN, 32, data width.
REG_AW, 5, register index width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
stall  in  1  hold all stages this cycle
flush  in  1  invalidate all stages this cycle
in_we  in  1  write enable from W stage (load op)
in_rd  in  REG_AW  destination register
in_data  in  XLEN  loaded data
out_we  out  1  write enable to register file (tail stage)
out_rd  out  REG_AW  tail destination
out_data  out  XLEN  tail data
occ  out  $clog2(DEPTH+1)  count of valid stages
fwd_rs1  in  REG_AW  forwarding query 1
fwd_rs2  in  REG_AW  forwarding query 2
fwd_hit1  out  1  query 1 matched a valid stage
fwd_data1  out  XLEN  forwarded data for query 1
fwd_hit2  out  1  query 2 matched a valid stage
fwd_data2  out  XLEN  forwarded data for query 2

Behaviour:
- Reset (async, active-high): all stage we/rd/data cleared to 0. out_we=0, out_rd=0, out_data=0, occ=0, fwd_hit*=0, fwd_data*=0. Reset asserted mid-operation clears pending writes immediately, without waiting for a clock edge.
- Normal cycle (no stall, no flush): on the rising edge, stage[0] ← {in_we & (in_rd≠0), in_rd, in_data}, and stage[i] ← stage[i-1]. Outputs come from stage[DEPTH-1]. Latency from input to out_* is exactly DEPTH clock edges.
- x0 rule: a write to rd=0 is stored with we=0. It never asserts out_we and never hits forwarding.
- stall=1: every stage holds, and the input is not captured. Outputs stay stable.
- flush=1: on the edge, all we bits and rd fields are cleared to 0 and data is cleared to 0. The input is dropped. flush has priority over stall.
- occ: registered population count of the stage we bits. It updates on the same edge as the stages.
- Forwarding (combinational from registered stages only, no input bypass): hitN=1 when some stage has we=1 and rd==fwd_rsN, with fwd_rsN≠0. On multiple matches, the youngest stage (lowest index) wins. fwd_dataN=0 when there is no hit.
- The tail stage takes part in forwarding on the same cycle it drives out_we.
- Elaboration error when DEPTH<1.

Optional Feature:
WBB_FWD_EN. When defined, the forwarding match logic is built as described. When undefined, the fwd_rs* inputs are ignored, fwd_hit*=0 and fwd_data*=0 permanently, and the ports remain present so the top level is unchanged.

Decomposition:
- skylark_pkg holds XLEN, REG_AW and typedef wb_entry_t (packed struct {logic we; logic [REG_AW-1:0] rd; logic [XLEN-1:0] data}).
- The stage array is declared as wb_entry_t stage[DEPTH].
- One sub-module: wbb_fwd_match. It takes the DEPTH entries and one query index, and outputs a priority-encoded {hit, data}. It is instantiated twice, once per query, under WBB_FWD_EN.

Test Plan:
1. DEPTH=2; drive in_we=1, in_rd=5, in_data=0xDEADBEEF for one cycle → out_we=1, out_rd=5, out_data=0xDEADBEEF after the 2nd edge, with occ stepping 1,1,0.
2. Write rd=0, data=0x12345678 → out_we stays 0, occ stays 0, and fwd_rs1=0 gives fwd_hit1=0.
3. stage0={1,7,0x11} and stage1={1,7,0x22}; fwd_rs1=7, fwd_rs2=3 → fwd_hit1=1, fwd_data1=0x11, fwd_hit2=0, fwd_data2=0.
4. Two valid entries; hold stall for 3 cycles → outputs and occ are unchanged. Then raise stall and flush together → occ=0 and out_we=0 after one edge, and the concurrent input is dropped.
5. Three writes pending; assert reset between edges → out_*, occ and fwd_* are 0 immediately. After reset deasserts, a new write emerges 2 edges later.
6. Build without WBB_FWD_EN and repeat scenario 3 → fwd_hit*=0, fwd_data*=0. DEPTH=1 build: a write appears after 1 edge, matching the legacy timing.

Source files
------------

// File: rtl/skylark_pkg.sv
// Shared Skylark-V writeback types: register-file geometry and the delay-buffer entry.
package skylark_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wbb_fwd_match.sv
// Priority match of one register index against all delay-buffer stages.
// Lowest stage index is the youngest write and wins when several stages match.
module wbb_fwd_match
    import skylark_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wb_entry_t         entries [DEPTH],
    input  logic [REG_AW-1:0] rs,
    output logic              hit,
    output logic [XLEN-1:0]   data
);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        // Walk oldest to youngest so the youngest match overwrites last.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (entries[i].we && (entries[i].rd == rs) && (rs != '0)) begin
                hit  = 1'b1;
                data = entries[i].data;
            end
        end
    end

endmodule

// File: rtl/wb_delay_buf.sv
// DEPTH-stage writeback delay buffer carrying {we, rd, data} toward the register file.
// Define WBB_FWD_EN to build the per-stage forwarding match; otherwise fwd_hit*/fwd_data* tie to 0.
module wb_delay_buf #(
    parameter int DEPTH  = 2,
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       in_we,
    input  logic [REG_AW-1:0]          in_rd,
    input  logic [XLEN-1:0]            in_data,
    output logic                       out_we,
    output logic [REG_AW-1:0]          out_rd,
    output logic [XLEN-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0] occ,
    input  logic [REG_AW-1:0]          fwd_rs1,
    input  logic [REG_AW-1:0]          fwd_rs2,
    output logic                       fwd_hit1,
    output logic [XLEN-1:0]            fwd_data1,
    output logic                       fwd_hit2,
    output logic [XLEN-1:0]            fwd_data2
);

    import skylark_pkg::wb_entry_t;

    localparam int OCC_W = $clog2(DEPTH + 1);

    if (DEPTH < 1) begin : g_bad_depth
        $error("wb_delay_buf: DEPTH must be at least 1");
    end
    // The entry struct is fixed by the package, so the widths must agree with it.
    if (XLEN != skylark_pkg::XLEN || REG_AW != skylark_pkg::REG_AW) begin : g_bad_width
        $error("wb_delay_buf: XLEN/REG_AW must match skylark_pkg");
    end

    wb_entry_t        stage_q [DEPTH];
    wb_entry_t        stage_d [DEPTH];
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = '0;
            end
        end else if (!stall) begin
            stage_d[0].we   = in_we & (in_rd != '0);
            stage_d[0].rd   = in_rd;
            stage_d[0].data = in_data;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCC_W'(stage_d[i].we);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            occ_q <= '0;
        end else begin
            stage_q <= stage_d;
            occ_q   <= occ_d;
        end
    end

    assign out_we   = stage_q[DEPTH-1].we;
    assign out_rd   = stage_q[DEPTH-1].rd;
    assign out_data = stage_q[DEPTH-1].data;
    assign occ      = occ_q;

`ifdef WBB_FWD_EN
    wbb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .entries (stage_q),
        .rs      (fwd_rs1),
        .hit     (fwd_hit1),
        .data    (fwd_data1)
    );

    wbb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .entries (stage_q),
        .rs      (fwd_rs2),
        .hit     (fwd_hit2),
        .data    (fwd_data2)
    );
`else
    logic unused_fwd_rs;
    assign unused_fwd_rs = ^{fwd_rs1, fwd_rs2};

    assign fwd_hit1  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_wb_delay_buf.sv
// Directed bench for wb_delay_buf: DEPTH=2 main instance plus a DEPTH=1 legacy instance on the same inputs.
module tb_wb_delay_buf;

`ifdef WBB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush;
    logic        in_we;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic [4:0]  fwd_rs1, fwd_rs2;

    logic        out_we;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic [1:0]  occ;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;

    logic        l_out_we;
    logic [4:0]  l_out_rd;
    logic [31:0] l_out_data;
    logic [0:0]  l_occ;
    logic        l_fwd_hit1, l_fwd_hit2;
    logic [31:0] l_fwd_data1, l_fwd_data2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_delay_buf #(.DEPTH(2), .XLEN(32), .REG_AW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .in_we     (in_we),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .out_we    (out_we),
        .out_rd    (out_rd),
        .out_data  (out_data),
        .occ       (occ),
        .fwd_rs1   (fwd_rs1),
        .fwd_rs2   (fwd_rs2),
        .fwd_hit1  (fwd_hit1),
        .fwd_data1 (fwd_data1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data2 (fwd_data2)
    );

    wb_delay_buf #(.DEPTH(1), .XLEN(32), .REG_AW(5)) dut_legacy (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .in_we     (in_we),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .out_we    (l_out_we),
        .out_rd    (l_out_rd),
        .out_data  (l_out_data),
        .occ       (l_occ),
        .fwd_rs1   (fwd_rs1),
        .fwd_rs2   (fwd_rs2),
        .fwd_hit1  (l_fwd_hit1),
        .fwd_data1 (l_fwd_data1),
        .fwd_hit2  (l_fwd_hit2),
        .fwd_data2 (l_fwd_data2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] data);
        in_we   = we;
        in_rd   = rd;
        in_data = data;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 5'd0, 32'h0);
        fwd_rs1 = 5'd5;
        fwd_rs2 = 5'd0;
        #3;
        check("rst_out_we",   {31'b0, out_we}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_occ",      {30'b0, occ}, 32'd0);
        check("rst_fwd_hit1", {31'b0, fwd_hit1}, 32'd0);
        #4;
        reset = 1'b0;
        #4;

        // Single load to x5: visible on out_* after two edges.
        drive(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        drive(1'b0, 5'd0, 32'h0);
        check("t1_occ_e1",      {30'b0, occ}, 32'd1);
        check("t1_out_we_e1",   {31'b0, out_we}, 32'd0);
        check("t1_leg_out_we",  {31'b0, l_out_we}, 32'd1);
        check("t1_leg_out_rd",  {27'b0, l_out_rd}, 32'd5);
        check("t1_fwd_hit1",    {31'b0, fwd_hit1}, {31'b0, FWD});
        check("t1_fwd_data1",   fwd_data1, FWD ? 32'hDEADBEEF : 32'h0);
        tick();
        check("t1_occ_e2",      {30'b0, occ}, 32'd1);
        check("t1_out_we_e2",   {31'b0, out_we}, 32'd1);
        check("t1_out_rd_e2",   {27'b0, out_rd}, 32'd5);
        check("t1_out_data_e2", out_data, 32'hDEADBEEF);
        check("t1_leg_off",     {31'b0, l_out_we}, 32'd0);
        tick();
        check("t1_occ_e3",      {30'b0, occ}, 32'd0);
        check("t1_out_we_e3",   {31'b0, out_we}, 32'd0);

        // Write to x0 is carried but never enabled.
        drive(1'b1, 5'd0, 32'h12345678);
        fwd_rs1 = 5'd0;
        tick();
        drive(1'b0, 5'd0, 32'h0);
        check("t2_occ_e1",    {30'b0, occ}, 32'd0);
        check("t2_fwd_hit1",  {31'b0, fwd_hit1}, 32'd0);
        check("t2_leg_we",    {31'b0, l_out_we}, 32'd0);
        tick();
        check("t2_out_we",    {31'b0, out_we}, 32'd0);
        check("t2_out_data",  out_data, 32'h12345678);
        check("t2_occ_e2",    {30'b0, occ}, 32'd0);

        // Two in-flight writes to x7; youngest (0x11) must win forwarding.
        drive(1'b1, 5'd7, 32'h22);
        tick();
        drive(1'b1, 5'd7, 32'h11);
        tick();
        drive(1'b0, 5'd0, 32'h0);
        fwd_rs1 = 5'd7;
        fwd_rs2 = 5'd3;
        #1;
        check("t3_occ",       {30'b0, occ}, 32'd2);
        check("t3_fwd_hit1",  {31'b0, fwd_hit1}, {31'b0, FWD});
        check("t3_fwd_data1", fwd_data1, FWD ? 32'h11 : 32'h0);
        check("t3_fwd_hit2",  {31'b0, fwd_hit2}, 32'd0);
        check("t3_fwd_data2", fwd_data2, 32'h0);
        check("t3_out_data",  out_data, 32'h22);

        // Stall three cycles with a pending input: nothing moves.
        stall = 1'b1;
        drive(1'b1, 5'd9, 32'h99);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t4_stall_occ",  {30'b0, occ}, 32'd2);
            check("t4_stall_rd",   {27'b0, out_rd}, 32'd7);
            check("t4_stall_data", out_data, 32'h22);
            check("t4_stall_we",   {31'b0, out_we}, 32'd1);
        end
        check("t4_leg_stall_data", l_out_data, 32'h11);
        flush = 1'b1;
        tick();
        check("t4_flush_occ",  {30'b0, occ}, 32'd0);
        check("t4_flush_we",   {31'b0, out_we}, 32'd0);
        check("t4_flush_rd",   {27'b0, out_rd}, 32'd0);
        check("t4_flush_data", out_data, 32'h0);
        check("t4_flush_hit1", {31'b0, fwd_hit1}, 32'd0);
        check("t4_leg_flush",  {31'b0, l_out_we}, 32'd0);
        flush = 1'b0;
        stall = 1'b0;
        drive(1'b0, 5'd0, 32'h0);
        tick();
        check("t4_drop_occ",   {30'b0, occ}, 32'd0);
        check("t4_drop_we",    {31'b0, out_we}, 32'd0);

        // Tail stage forwards on the same cycle it writes back.
        drive(1'b1, 5'd4, 32'h44);
        tick();
        drive(1'b1, 5'd6, 32'h66);
        tick();
        drive(1'b0, 5'd0, 32'h0);
        fwd_rs1 = 5'd4;
        fwd_rs2 = 5'd6;
        #1;
        check("tail_out_rd",   {27'b0, out_rd}, 32'd4);
        check("tail_fwd_hit1", {31'b0, fwd_hit1}, {31'b0, FWD});
        check("tail_fwd_data1", fwd_data1, FWD ? 32'h44 : 32'h0);
        check("tail_fwd_data2", fwd_data2, FWD ? 32'h66 : 32'h0);
        check("tail_leg_rd",   {27'b0, l_out_rd}, 32'd6);
        check("tail_leg_hit1", {31'b0, l_fwd_hit1}, 32'd0);
        tick();

        // Asynchronous reset between edges clears everything at once.
        drive(1'b1, 5'd1, 32'hA1);
        tick();
        drive(1'b1, 5'd2, 32'hA2);
        tick();
        drive(1'b1, 5'd3, 32'hA3);
        tick();
        drive(1'b0, 5'd0, 32'h0);
        fwd_rs1 = 5'd3;
        fwd_rs2 = 5'd2;
        check("t5_pre_occ", {30'b0, occ}, 32'd2);
        #1;
        reset = 1'b1;
        #1;
        check("t5_rst_out_we",   {31'b0, out_we}, 32'd0);
        check("t5_rst_out_rd",   {27'b0, out_rd}, 32'd0);
        check("t5_rst_out_data", out_data, 32'h0);
        check("t5_rst_occ",      {30'b0, occ}, 32'd0);
        check("t5_rst_hit1",     {31'b0, fwd_hit1}, 32'd0);
        check("t5_rst_data2",    fwd_data2, 32'h0);
        check("t5_rst_leg_we",   {31'b0, l_out_we}, 32'd0);
        #1;
        reset = 1'b0;
        drive(1'b1, 5'd10, 32'hA5A5);
        tick();
        drive(1'b0, 5'd0, 32'h0);
        check("t5_post_we_e1",  {31'b0, out_we}, 32'd0);
        check("t5_leg_we_e1",   {31'b0, l_out_we}, 32'd1);
        check("t5_leg_occ_e1",  {31'b0, l_occ}, 32'd1);
        tick();
        check("t5_post_we_e2",  {31'b0, out_we}, 32'd1);
        check("t5_post_rd_e2",  {27'b0, out_rd}, 32'd10);
        check("t5_post_data",   out_data, 32'hA5A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
